// File: rtl/li_pkg.sv
// Shared definitions for the load-immediate expander: the I-type opcodes it emits,
// the FSM state type, the expansion kinds and the I-type word packer.
package li_pkg;

    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT1 = 2'd1,
        ST_EMIT2 = 2'd2
    } state_t;

    // How a 32-bit constant gets materialised.
    typedef enum logic [1:0] {
        K_ORI   = 2'd0,   // upper half zero
        K_ADDIU = 2'd1,   // sign-extension of the lower half
        K_LUI   = 2'd2,   // lower half zero
        K_PAIR  = 2'd3    // LUI followed by ORI
    } kind_t;

    // Packs op[31:26], rs[25:21], rt[20:16], imm[15:0].
    function automatic logic [31:0] encode_itype(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/li_classify.sv
// Combinational classifier: decides which instruction sequence loads imm32 and
// splits it into its 16-bit halves.
module li_classify
    import li_pkg::*;
(
    input  logic [31:0] imm,
    output kind_t       kind,
    output logic [15:0] hi,
    output logic [15:0] lo
);

    assign hi = imm[31:16];
    assign lo = imm[15:0];

    // Priority matters: 0 must become ORI, and 0xFFFF8000.. must be ADDIU before the LUI test.
    always_comb begin
        if (imm[31:16] == 16'h0000)
            kind = K_ORI;
        else if (&imm[31:15])
            kind = K_ADDIU;
        else if (imm[15:0] == 16'h0000)
            kind = K_LUI;
        else
            kind = K_PAIR;
    end

endmodule

// File: rtl/li_expander.sv
// Load-immediate expander: turns (rt, imm32) into one or two MIPS instruction words
// (ORI / ADDIU / LUI / LUI+ORI) with valid/ready handshakes on both sides.
// Optional build macro LI_DROP_ZERO_EN: requests targeting $0 are accepted and dropped.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a request, in_ready=1
// ST_EMIT1 | presenting first word (ORI/ADDIU/LUI), out_last=1 unless pair
// ST_EMIT2 | presenting trailing ORI rt,rt,L of a pair, out_last=1
module li_expander
    import li_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rt,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] words_emitted
);

    state_t      state;
    kind_t       kind_q;
    logic [4:0]  rt_q;
    logic [15:0] hi_q;
    logic [15:0] lo_q;

    kind_t       cls_kind;
    logic [15:0] cls_hi;
    logic [15:0] cls_lo;

    li_classify u_classify (
        .imm  (in_imm),
        .kind (cls_kind),
        .hi   (cls_hi),
        .lo   (cls_lo)
    );

    logic accept_go;

`ifdef LI_DROP_ZERO_EN
    assign accept_go = (in_rt != 5'd0);
`else
    assign accept_go = 1'b1;
`endif

    // State sequencing, request capture and the handshake counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            kind_q        <= K_ORI;
            rt_q          <= 5'd0;
            hi_q          <= 16'h0000;
            lo_q          <= 16'h0000;
            words_emitted <= '0;
        end else begin
            if (out_valid && out_ready)
                words_emitted <= words_emitted + CNT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        kind_q <= cls_kind;
                        rt_q   <= in_rt;
                        hi_q   <= cls_hi;
                        lo_q   <= cls_lo;
                        if (accept_go)
                            state <= ST_EMIT1;
                    end
                end
                ST_EMIT1: begin
                    if (out_ready)
                        state <= (kind_q == K_PAIR) ? ST_EMIT2 : ST_IDLE;
                end
                ST_EMIT2: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags follow the state directly.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_EMIT1) || (state == ST_EMIT2);
        busy      = (state != ST_IDLE);
    end

    // Output word is built from latched fields only, so it holds steady under stall.
    always_comb begin
        out_instr = 32'h0000_0000;
        out_last  = 1'b0;
        case (state)
            ST_EMIT1: begin
                out_last = (kind_q != K_PAIR);
                case (kind_q)
                    K_ORI:   out_instr = encode_itype(OP_ORI,   5'd0, rt_q, lo_q);
                    K_ADDIU: out_instr = encode_itype(OP_ADDIU, 5'd0, rt_q, lo_q);
                    default: out_instr = encode_itype(OP_LUI,   5'd0, rt_q, hi_q);
                endcase
            end
            ST_EMIT2: begin
                out_last  = 1'b1;
                out_instr = encode_itype(OP_ORI, rt_q, rt_q, lo_q);
            end
            default: begin
                out_instr = 32'h0000_0000;
                out_last  = 1'b0;
            end
        endcase
    end

endmodule
